violation_logger: RTL and testbench

VIOLATION_LOGGER -- requirements
Module: violation_logger

---
 rtl/traffic_pkg.sv | 17 +
 rtl/violation_logger_if.sv | 23 ++
 rtl/viol_fifo.sv | 64 ++++++
 rtl/violation_logger.sv | 191 +++++++++++++++++++
 tb/tb_violation_logger.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared widths, default parameters and FSM encoding for violation_logger.
package traffic_pkg;

    localparam int TS_W   = 16;
    localparam int CNT_W  = 8;
    localparam int MISS_W = 4;

    localparam int DEF_DEBOUNCE_CYC = 2;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_ACK_TIMEOUT  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/violation_logger_if.sv
// violation_logger_if: camera handshake and record-FIFO read port.
// master = the logger, slave = camera / record consumer.
interface violation_logger_if;
    import traffic_pkg::*;

    logic            shot_req;
    logic            shot_ack;
    logic            rd_en;
    logic [TS_W-1:0] rec_data;
    logic            rec_valid;
    logic            fifo_full;

    modport master (
        output shot_req, rec_data, rec_valid, fifo_full,
        input  shot_ack, rd_en
    );

    modport slave (
        input  shot_req, rec_data, rec_valid, fifo_full,
        output shot_ack, rd_en
    );

endinterface

// File: rtl/viol_fifo.sv
// viol_fifo: synchronous first-word-fall-through record FIFO.
// A pop is applied before a push in the same cycle, so a full FIFO can
// accept a push together with a pop. rd_data reads 0 while empty.
module viol_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full,
    output logic         dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_pop, do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pop first, then accept the push if a slot is (or has just become) free.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        dropped  = push && !do_push;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/violation_logger.sv
// violation_logger: red-light violation detector with camera handshake,
// timestamp record FIFO, saturating violation counter and sticky overflow flag.
// Build macro VIOLATION_MISS_CNT_EN adds miss_cnt, a saturating count of
// camera handshakes that expired without shot_ack.
// The stop-line sensor port is cross_in because "cross" is a reserved word.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for a violation
//   ST_REQ  | shot_req high, waiting for shot_ack or timer expiry
module violation_logger
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               red,
    input  logic               camera,
    input  logic               cross_in,
    violation_logger_if.master bus,
    output logic [CNT_W-1:0]   viol_cnt,
    output logic               ovf
`ifdef VIOLATION_MISS_CNT_EN
    ,
    output logic [MISS_W-1:0]  miss_cnt
`endif
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    logic             rst_meta_q, rst_sync_q, rst_int_n;
    logic             x_meta_q, x_meta_d, x_sync_q, x_sync_d;
    logic             deb_q, deb_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [TS_W-1:0]  ts_q, ts_d, stamp_q, stamp_d;
    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             shot_req_q, shot_req_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic             ovf_q, ovf_d;
    logic             viol, push, dropped, fifo_empty, fifo_full_w;
    logic [TS_W-1:0]  rec_data_w;
`ifdef VIOLATION_MISS_CNT_EN
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic              timeout;
`endif

    // Reset asserts immediately and releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_int_n = rst_sync_q;

    // Sensor synchroniser, debouncer and violation detect. The violation is
    // flagged on the cycle the accepted level flips, so REQ and the stamp line
    // up with the first cycle the debounced level reads high.
    always_comb begin
        x_meta_d = cross_in;
        x_sync_d = x_meta_q;
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (x_sync_q != deb_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                deb_d = x_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        viol = deb_d && !deb_q && red && camera;
        ts_d = ts_q + TS_W'(1);
    end

    // Camera handshake FSM with ACK_TIMEOUT down-counter, plus counters.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        stamp_d    = stamp_q;
        push       = 1'b0;
`ifdef VIOLATION_MISS_CNT_EN
        timeout    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (viol) begin
                    state_d = ST_REQ;
                    tmr_d   = TMR_W'(ACK_TIMEOUT - 1);
                    stamp_d = ts_d;
                end
            end
            ST_REQ: begin
                if (bus.shot_ack) begin
                    state_d = ST_IDLE;
                    push    = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d = ST_IDLE;
`ifdef VIOLATION_MISS_CNT_EN
                    timeout = 1'b1;
`endif
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        shot_req_d = (state_d == ST_REQ);
        viol_cnt_d = viol_cnt_q;
        if (viol && (viol_cnt_q != {CNT_W{1'b1}})) begin
            viol_cnt_d = viol_cnt_q + CNT_W'(1);
        end
        ovf_d = ovf_q | dropped;
`ifdef VIOLATION_MISS_CNT_EN
        miss_cnt_d = miss_cnt_q;
        if (timeout && (miss_cnt_q != {MISS_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
        end
`endif
    end

    // Main state registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            x_meta_q   <= 1'b0;
            x_sync_q   <= 1'b0;
            deb_q      <= 1'b0;
            db_cnt_q   <= '0;
            ts_q       <= '0;
            stamp_q    <= '0;
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            shot_req_q <= 1'b0;
            viol_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            x_meta_q   <= x_meta_d;
            x_sync_q   <= x_sync_d;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            ts_q       <= ts_d;
            stamp_q    <= stamp_d;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            shot_req_q <= shot_req_d;
            viol_cnt_q <= viol_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef VIOLATION_MISS_CNT_EN
    // Handshake-timeout counter.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end
    assign miss_cnt = miss_cnt_q;
`endif

    viol_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .push    (push),
        .wr_data (stamp_q),
        .pop     (bus.rd_en),
        .rd_data (rec_data_w),
        .empty   (fifo_empty),
        .full    (fifo_full_w),
        .dropped (dropped)
    );

    assign bus.shot_req  = shot_req_q;
    assign bus.rec_data  = rec_data_w;
    assign bus.rec_valid = !fifo_empty;
    assign bus.fifo_full = fifo_full_w;
    assign viol_cnt      = viol_cnt_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_violation_logger.sv
// tb_violation_logger: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model (sample windows, a pending-shot record and a
// record queue), with literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_violation_logger;
    import traffic_pkg::*;

    localparam int DC = 2;
    localparam int FD = 4;
    localparam int AT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             red = 1'b0;
    logic             camera = 1'b0;
    logic             cross_in = 1'b0;
    logic [CNT_W-1:0] viol_cnt;
    logic             ovf;
`ifdef VIOLATION_MISS_CNT_EN
    logic [MISS_W-1:0] miss_cnt;
`endif

    violation_logger_if bus_if ();

    violation_logger #(
        .DEBOUNCE_CYC (DC),
        .FIFO_DEPTH   (FD),
        .ACK_TIMEOUT  (AT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .red      (red),
        .camera   (camera),
        .cross_in (cross_in),
        .bus      (bus_if),
        .viol_cnt (viol_cnt),
        .ovf      (ovf)
`ifdef VIOLATION_MISS_CNT_EN
        ,
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_hold;
    bit  m_c1, m_c2;
    bit  m_win[$];
    bit  m_deb;
    int  m_ts;
    bit  m_busy;
    int  m_left;
    int  m_stamp;
    int  m_q[$];
    int  m_vcnt;
    int  m_miss;
    bit  m_ovf;

    task automatic model_reset();
        m_c1 = 0; m_c2 = 0; m_win.delete(); m_deb = 0; m_ts = 0;
        m_busy = 0; m_left = 0; m_stamp = 0; m_q.delete();
        m_vcnt = 0; m_miss = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit x, input bit ack, input bit rd);
        bit samp, rise, viol, all_diff, do_push;
        // synchronised sample is the raw level from two clocks earlier
        samp = m_c2; m_c2 = m_c1; m_c1 = x;
        m_win.push_back(samp);
        if (m_win.size() > DC) void'(m_win.pop_front());
        rise = 0;
        if (m_win.size() == DC) begin
            all_diff = 1;
            foreach (m_win[i]) if (m_win[i] == m_deb) all_diff = 0;
            if (all_diff) begin
                rise  = !m_deb;
                m_deb = !m_deb;
            end
        end
        viol = rise && r && c;
        m_ts = (m_ts + 1) & 32'hFFFF;
        do_push = 0;
        if (m_busy) begin
            if (ack) begin
                m_busy = 0; do_push = 1;
            end else if (m_left == 1) begin
                m_busy = 0;
                if (m_miss < 15) m_miss++;
            end else begin
                m_left--;
            end
        end else if (viol) begin
            m_busy = 1; m_left = AT; m_stamp = m_ts;
        end
        if (viol && m_vcnt < 255) m_vcnt++;
        if (rd && m_q.size() > 0) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < FD) m_q.push_back(m_stamp);
            else m_ovf = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            m_hold = 2;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            model_step(red, camera, cross_in, bus_if.shot_ack, bus_if.rd_en);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("shot_req",  bus_if.shot_req,  m_busy);
            chk("rec_valid", bus_if.rec_valid, m_q.size() > 0);
            chk("rec_data",  bus_if.rec_data,  (m_q.size() > 0) ? m_q[0] : 0);
            chk("fifo_full", bus_if.fifo_full, m_q.size() == FD);
            chk("viol_cnt",  viol_cnt,         m_vcnt);
            chk("ovf",       ovf,              m_ovf);
`ifdef VIOLATION_MISS_CNT_EN
            chk("miss_cnt",  miss_cnt,         m_miss);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        red = 0; camera = 0; cross_in = 0;
        bus_if.shot_ack = 0; bus_if.rd_en = 0;
        rst_n = 0;
        #1 check_en = 1;
        tick(3);
        rst_n = 1;
        tick(2);
    endtask

    task automatic wait_ts(input int t);
        int n = 0;
        while (m_ts != t && n < 300) begin
            tick(1);
            n++;
        end
        chk("ts_reach", m_ts, t);
    endtask

    task automatic wait_shot(output int ts_at);
        int n = 0;
        while (bus_if.shot_req !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("shot_req_wait", n < 20, 1'b1);
        ts_at = m_ts;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int t, len;
        int stamps[5];
        bit cur;
        int run;

        #1;
        // ---- single acked violation at ts 100 ----
        do_reset();
        chk("rst_viol_cnt", viol_cnt, 0);
        chk("rst_rec_valid", bus_if.rec_valid, 0);
        red = 1; camera = 1;
        wait_ts(100);
        cross_in = 1;
        tick(3);
        chk("s1_req_ts103", bus_if.shot_req, 0);
        tick(1);
        chk("s1_req_ts104", bus_if.shot_req, 1);
        chk("s1_model_busy", m_busy, 1);
        tick(1);
        cross_in = 0;
        tick(1);
        bus_if.shot_ack = 1;
        tick(1);
        bus_if.shot_ack = 0;
        chk("s1_rec_valid", bus_if.rec_valid, 1);
        chk("s1_rec_data", bus_if.rec_data, 104);
        chk("s1_model_rec", (m_q.size() > 0) ? m_q[0] : 0, 104);
        chk("s1_viol_cnt", viol_cnt, 1);
        chk("s1_req_low", bus_if.shot_req, 0);
        bus_if.rd_en = 1;
        tick(1);
        bus_if.rd_en = 0;
        chk("s1_popped", bus_if.rec_valid, 0);

        // ---- one-cycle glitch ----
        do_reset();
        red = 1; camera = 1;
        tick(5);
        cross_in = 1;
        tick(1);
        cross_in = 0;
        tick(10);
        chk("s2_viol_cnt", viol_cnt, 0);
        chk("s2_shot_req", bus_if.shot_req, 0);
        chk("s2_model_cnt", m_vcnt, 0);

        // ---- timeout ----
        do_reset();
        red = 1; camera = 1; cross_in = 1;
        wait_shot(t);
        len = 0;
        while (bus_if.shot_req === 1'b1 && len < 20) begin
            len++;
            tick(1);
        end
        cross_in = 0;
        chk("s3_req_len", len, 8);
        chk("s3_rec_valid", bus_if.rec_valid, 0);
        chk("s3_viol_cnt", viol_cnt, 1);
`ifdef VIOLATION_MISS_CNT_EN
        chk("s3_miss_cnt", miss_cnt, 1);
`endif

        // ---- fill FIFO and overflow ----
        do_reset();
        red = 1; camera = 1;
        for (int k = 0; k < 5; k++) begin
            cross_in = 1;
            wait_shot(stamps[k]);
            cross_in = 0;
            tick(1);
            bus_if.shot_ack = 1;
            tick(1);
            bus_if.shot_ack = 0;
            tick(6);
            if (k == 3) begin
                chk("s4_full_after4", bus_if.fifo_full, 1);
                chk("s4_ovf_after4", ovf, 0);
            end
        end
        chk("s4_ovf_after5", ovf, 1);
        chk("s4_full_after5", bus_if.fifo_full, 1);
        chk("s4_viol_cnt", viol_cnt, 5);
        for (int i = 0; i < 4; i++) begin
            chk("s4_pop_order", bus_if.rec_data, stamps[i]);
            bus_if.rd_en = 1;
            tick(1);
            bus_if.rd_en = 0;
        end
        chk("s4_empty", bus_if.rec_valid, 0);
        chk("s4_ovf_sticky", ovf, 1);

        // ---- second violation during REQ ----
        do_reset();
        red = 1; camera = 1; cross_in = 1;
        wait_shot(t);
        cross_in = 0;
        tick(3);
        cross_in = 1;
        tick(4);
        bus_if.shot_ack = 1;
        tick(1);
        bus_if.shot_ack = 0;
        cross_in = 0;
        chk("s5_viol_cnt", viol_cnt, 2);
        chk("s5_rec_data", bus_if.rec_data, t);
        chk("s5_not_rearmed", bus_if.shot_req, 0);
        bus_if.rd_en = 1;
        tick(1);
        bus_if.rd_en = 0;
        chk("s5_one_record", bus_if.rec_valid, 0);
        tick(4);
        chk("s5_still_idle", bus_if.shot_req, 0);

        // ---- reset during REQ ----
        do_reset();
        red = 1; camera = 1; cross_in = 1;
        wait_shot(t);
        tick(1);
        #1 rst_n = 0;
        #1;
        chk("s6_req", bus_if.shot_req, 0);
        chk("s6_valid", bus_if.rec_valid, 0);
        chk("s6_full", bus_if.fifo_full, 0);
        chk("s6_data", bus_if.rec_data, 0);
        chk("s6_cnt", viol_cnt, 0);
        chk("s6_ovf", ovf, 0);
        cross_in = 0;
        tick(2);
        rst_n = 1;
        tick(5);
        chk("s6_no_record", bus_if.rec_valid, 0);
        cross_in = 1;
        wait_shot(t);
        bus_if.shot_ack = 1;
        tick(1);
        bus_if.shot_ack = 0;
        cross_in = 0;
        chk("s6_after_rec", bus_if.rec_data, t);
        chk("s6_after_cnt", viol_cnt, 1);

        // ---- viol_cnt saturation ----
        do_reset();
        red = 1; camera = 1;
        for (int k = 0; k < 262; k++) begin
            cross_in = 1;
            bus_if.shot_ack = ($urandom_range(0, 1) == 0);
            bus_if.rd_en = 1;
            tick(3);
            cross_in = 0;
            tick(3);
        end
        bus_if.shot_ack = 0;
        bus_if.rd_en = 0;
        chk("s7_saturated", viol_cnt, 255);

        // ---- randomized traffic ----
        do_reset();
        cur = 0;
        run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                cur = ($urandom_range(0, 2) != 0) ? !cur : cur;
                run = $urandom_range(1, 6);
            end
            run--;
            cross_in = cur;
            red      = ($urandom_range(0, 3) != 0);
            camera   = ($urandom_range(0, 3) != 0);
            bus_if.shot_ack = (bus_if.shot_req === 1'b1) ? ($urandom_range(0, 3) == 0)
                                                         : ($urandom_range(0, 9) == 0);
            bus_if.rd_en = ($urandom_range(0, 4) == 0);
            tick(1);
        end
        bus_if.shot_ack = 0;
        bus_if.rd_en = 0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
